// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage that feeds the OpFn control decoder. It holds the
//   PC, reads one instruction word at a time from instruction memory, and
//   presents it to decode/execute. When decode/execute retires the
//   instruction, the PC advances to PC+1 (nia=1) or to branch_target (nia=0).
//
//   State machine: IDLE -> REQ -> HOLD -> REQ -> HOLD ...
//     IDLE : one cycle after reset with no request and no valid instruction
//     REQ  : imem_req high, imem_addr = pc, waiting for imem_ack
//     HOLD : IR valid, waiting for instr_accept
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_req        instruction-memory read request (registered)
//   imem_addr       read address, always equal to pc
//   imem_ack        read data valid this cycle (only honoured in REQ)
//   imem_rdata      read data
//   instr           instruction register
//   opfn            top OPFN_W bits of instr
//   instr_valid     instr holds an instruction for decode/execute (registered)
//   instr_accept    decode/execute retires instr (only honoured in HOLD)
//   nia             1 = next PC is pc+1, 0 = next PC is branch_target
//   branch_target   next PC when nia=0
//   pc              current PC
//   retired_cnt     count of accepted instructions, wraps
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter int                OPFN_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [OPFN_W-1:0]  opfn,
  output logic               instr_valid,
  input  logic               instr_accept,
  input  logic               nia,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic [CNT_W-1:0]   retired_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 req_q;
  logic                 valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // nia/branch_target only matter on the accepting edge.
        if (instr_accept) begin
          pc_d    = nia ? (pc_q + ADDR_W'(1)) : branch_target;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req/valid are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == REQ);
      valid_q <= (state_d == HOLD);
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opfn        = instr_q[INSTR_W-1 -: OPFN_W];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic [4:0]  opfn;
  logic        instr_valid;
  logic        instr_accept;
  logic        nia;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic [15:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural PC and retired count only.
  int unsigned exp_pc;
  int unsigned exp_cnt;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .opfn         (opfn),
    .instr_valid  (instr_valid),
    .instr_accept (instr_accept),
    .nia          (nia),
    .branch_target(branch_target),
    .pc           (pc),
    .retired_cnt  (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction transaction: entered and left with the DUT in REQ.
  // The ack arrives after ack_dly wait cycles, accept after acc_dly cycles.
  task automatic run_instr(input int ack_dly, input int acc_dly,
                           input logic n, input logic [7:0] tgt,
                           input logic [15:0] word, input logic stray);
    logic [4:0] e_op;
    e_op = word[15:11];
    for (int d = 0; d <= ack_dly; d++) begin
      checks++;
      if (imem_req !== 1'b1) begin
        errors++; $display("FAIL req_in_REQ: got %b want 1", imem_req);
      end
      checks++;
      if (imem_addr !== exp_pc[7:0]) begin
        errors++; $display("FAIL addr_in_REQ: got %h want %h", imem_addr, exp_pc[7:0]);
      end
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL valid_in_REQ: got %b want 0", instr_valid);
      end
      imem_ack      = (d == ack_dly);
      imem_rdata    = (d == ack_dly) ? word : 16'($urandom);
      instr_accept  = 1'($urandom);   // ignored outside HOLD
      nia           = 1'($urandom);
      branch_target = 8'($urandom);
      step();
    end
    imem_ack = 1'b0;
    instr_accept = 1'b0;
    for (int a = 0; a <= acc_dly; a++) begin
      checks++;
      if (instr_valid !== 1'b1) begin
        errors++; $display("FAIL valid_in_HOLD: got %b want 1", instr_valid);
      end
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL req_in_HOLD: got %b want 0", imem_req);
      end
      checks++;
      if (instr !== word) begin
        errors++; $display("FAIL instr_in_HOLD: got %h want %h", instr, word);
      end
      checks++;
      if (opfn !== e_op) begin
        errors++; $display("FAIL opfn: got %h want %h", opfn, e_op);
      end
      checks++;
      if (pc !== exp_pc[7:0]) begin
        errors++; $display("FAIL pc_in_HOLD: got %h want %h", pc, exp_pc[7:0]);
      end
      checks++;
      if (retired_cnt !== exp_cnt[15:0]) begin
        errors++; $display("FAIL cnt_in_HOLD: got %0d want %0d", retired_cnt, exp_cnt[15:0]);
      end
      if (a == acc_dly) begin
        instr_accept  = 1'b1;
        nia           = n;
        branch_target = tgt;
      end else begin
        instr_accept  = 1'b0;
        nia           = 1'($urandom);
        branch_target = 8'($urandom);
      end
      imem_ack   = stray && (a != acc_dly) ? 1'($urandom) : 1'b0;
      imem_rdata = 16'($urandom);
      step();
    end
    instr_accept = 1'b0;
    imem_ack     = 1'b0;
    exp_pc  = n ? (exp_pc + 1) % 256 : int'(tgt);
    exp_cnt = (exp_cnt + 1) % 65536;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_accept = 1'b0;
    nia = 1'b1; branch_target = '0;
    step(); step();
    exp_pc = 0; exp_cnt = 0;
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL rst_pc: got %h want 00", pc); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++;
    if (retired_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", retired_cnt); end
    checks++;
    if (instr !== 16'd0) begin errors++; $display("FAIL rst_instr: got %h want 0", instr); end
    rst = 1'b0;
    // Stray ack while in IDLE must not load the IR.
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL post_rst_req: got %b want 1", imem_req); end
    checks++;
    if (imem_addr !== 8'h00) begin errors++; $display("FAIL post_rst_addr: got %h want 00", imem_addr); end
    checks++;
    if (instr !== 16'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL idle_ack: got instr %h valid %b want 0000 0", instr, instr_valid);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) run_instr(0, 0, 1'b1, 8'h00, 16'($urandom), 1'b0);
    checks++;
    if (retired_cnt !== 16'd4) begin errors++; $display("FAIL seq_cnt: got %0d want 4", retired_cnt); end
    checks++;
    if (imem_addr !== 8'h04) begin errors++; $display("FAIL seq_addr: got %h want 04", imem_addr); end
  endtask

  task automatic test_branch();
    run_instr(0, 0, 1'b1, 8'h00, 16'hA5C3, 1'b0);       // pc 4 -> 5
    run_instr(0, 0, 1'b0, 8'h40, 16'h7FFF, 1'b0);       // at pc 5 branch to 0x40
    checks++;
    if (imem_addr !== 8'h40) begin errors++; $display("FAIL branch_addr: got %h want 40", imem_addr); end
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 1'b0, 8'hFF, 16'($urandom), 1'b0);
    run_instr(0, 0, 1'b1, 8'h33, 16'($urandom), 1'b0);
    checks++;
    if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h want 00", pc); end
  endtask

  task automatic test_stalls();
    run_instr(3, 5, 1'b1, 8'h00, 16'h1234, 1'b1);
    run_instr(2, 4, 1'b0, 8'h80, 16'hF00D, 1'b1);
  endtask

  task automatic test_self_loop();
    int unsigned here;
    here = exp_pc;
    for (int i = 0; i < 3; i++) run_instr(0, 1, 1'b0, here[7:0], 16'($urandom), 1'b0);
    checks++;
    if (imem_addr !== here[7:0]) begin errors++; $display("FAIL self_loop: got %h want %h", imem_addr, here[7:0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                8'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic test_reset_midreq();
    run_instr(0, 0, 1'b0, 8'h12, 16'($urandom), 1'b0);
    // Now in REQ at 0x12; reset with a simultaneous ack.
    checks++;
    if (imem_addr !== 8'h12) begin errors++; $display("FAIL midreq_pre: got %h want 12", imem_addr); end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hCAFE;
    step();
    rst = 1'b0; imem_ack = 1'b0;
    exp_pc = 0; exp_cnt = 0;
    checks++;
    if (instr !== 16'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL midreq_ir: got instr %h valid %b want 0000 0", instr, instr_valid);
    end
    checks++;
    if (pc !== 8'h00 || imem_req !== 1'b0) begin
      errors++; $display("FAIL midreq_state: got pc %h req %b want 00 0", pc, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL midreq_next: got req %b addr %h want 1 00", imem_req, imem_addr);
    end
    run_instr(1, 0, 1'b1, 8'h00, 16'($urandom), 1'b0);
    checks++;
    if (retired_cnt !== 16'd1) begin errors++; $display("FAIL midreq_cnt: got %0d want 1", retired_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_stalls();
    test_self_loop();
    test_random();
    test_reset_midreq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
